// File: rtl/m_store_buffer_pkg.sv
// m_store_buffer_pkg: constants and types shared by the store buffer and its
// entry RAM.
//   SB_DEPTH     default number of posted-write entries (power of two, >= 2)
//   SB_PTR_W     log2(SB_DEPTH)
//   SB_BYTEEN_W  byte-enable width of one 32-bit word
//   sb_entry_t   one stored write: word address, write data, byte enables
package m_store_buffer_pkg;

  localparam int SB_DEPTH    = 4;
  localparam int SB_PTR_W    = 2;
  localparam int SB_BYTEEN_W = 4;

  // 30 + 32 + 4 = 66 bits per entry
  typedef struct packed {
    logic [29:0]            addr;   // word address, byte address [31:2]
    logic [31:0]            data;
    logic [SB_BYTEEN_W-1:0] byteen;
  } sb_entry_t;

endpackage

// File: rtl/m_store_buffer_sb_entry_ram.sv
// sb_entry_ram: DEPTH x 66-bit register file backing the store buffer.
//   clk, reset       clock and asynchronous active-high reset (valid bits only)
//   wr_en/wr_idx/wr_entry  write port; a write marks its slot valid
//   pop_en/pop_idx   clears the valid bit of the entry leaving the head
//   rd_idx/rd_entry  head read port feeding the bus
//   tail_idx/tail_entry  tail read port used by the optional merge path
//   cmp_addr/match_vec   per-entry valid && word-address-equal vector
module sb_entry_ram
  import m_store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int PTR_W = SB_PTR_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_idx,
  input  sb_entry_t        wr_entry,
  input  logic             pop_en,
  input  logic [PTR_W-1:0] pop_idx,
  input  logic [PTR_W-1:0] rd_idx,
  output sb_entry_t        rd_entry,
  input  logic [PTR_W-1:0] tail_idx,
  output sb_entry_t        tail_entry,
  input  logic [29:0]      cmp_addr,
  output logic [DEPTH-1:0] match_vec
);

  sb_entry_t        mem_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;

  // NOTE: the data array has no reset; only the valid bits do. Stale data is
  // never observed because every consumer is qualified by valid or count.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= wr_entry;
  end

  // Pop and write never target the same slot in one cycle (a full buffer
  // refuses new allocations), so clearing before setting is order-safe.
  always_comb begin
    valid_d = valid_q;
    if (pop_en) valid_d[pop_idx] = 1'b0;
    if (wr_en)  valid_d[wr_idx]  = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) valid_q <= '0;
    else       valid_q <= valid_d;
  end

  assign rd_entry   = mem_q[rd_idx];
  assign tail_entry = mem_q[tail_idx];

  always_comb begin
    match_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match_vec[i] = valid_q[i] && (mem_q[i].addr == cmp_addr);
    end
  end

endmodule

// File: rtl/m_store_buffer.sv
// m_store_buffer: posted-write FIFO between the store byte-enable unit and the
// data-memory bus. Stores are queued in program order and drained with a
// req/ack handshake; stall requests are raised when full or when a load hits
// a word with a pending store.
//   clk, reset                         clock, asynchronous active-high reset
//   in_valid/in_addr/in_wdata/in_byteen  store from the M stage
//   store_full                         stall: store presented but not accepted
//   ld_valid/ld_addr, ld_hazard        load word-address hazard detection
//   bus_req/bus_addr/bus_wdata/bus_byteen, bus_ack  head-of-queue bus port
//   empty                              no pending stores (barrier)
// Build option: define STORE_MERGE_EN to merge a store into the tail entry
// when it targets the same word and the tail is not the bus head.
module m_store_buffer
  import m_store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int PTR_W = SB_PTR_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [31:0]            in_addr,
  input  logic [31:0]            in_wdata,
  input  logic [SB_BYTEEN_W-1:0] in_byteen,
  output logic                   store_full,
  input  logic                   ld_valid,
  input  logic [31:0]            ld_addr,
  output logic                   ld_hazard,
  output logic                   bus_req,
  output logic [31:0]            bus_addr,
  output logic [31:0]            bus_wdata,
  output logic [SB_BYTEEN_W-1:0] bus_byteen,
  input  logic                   bus_ack,
  output logic                   empty
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  logic             push_req, push, pop, merge;
  logic             wr_en;
  logic [PTR_W-1:0] wr_idx, tail_idx;
  sb_entry_t        wr_entry, head_entry, tail_entry;
  logic [DEPTH-1:0] match_vec;

  assign push_req = in_valid && (in_byteen != '0);
  assign tail_idx = wr_ptr_q - 1'b1;

`ifdef STORE_MERGE_EN
  // count >= 2 keeps the tail distinct from the head currently on the bus,
  // so a merge never alters data the bus may be sampling.
  assign merge = push_req && (count_q >= (PTR_W+1)'(2))
              && (tail_entry.addr == in_addr[31:2]);

  always_comb begin
    wr_entry = tail_entry;
    if (merge) begin
      for (int k = 0; k < SB_BYTEEN_W; k++) begin
        if (in_byteen[k]) wr_entry.data[8*k +: 8] = in_wdata[8*k +: 8];
      end
      wr_entry.byteen = tail_entry.byteen | in_byteen;
    end else begin
      wr_entry = '{addr: in_addr[31:2], data: in_wdata, byteen: in_byteen};
    end
  end
`else
  assign merge    = 1'b0;
  assign wr_entry = '{addr: in_addr[31:2], data: in_wdata, byteen: in_byteen};
`endif

  // No pass-through: a pop this cycle does not free a slot for this store.
  assign push       = push_req && !merge && (count_q != FULL_CNT);
  assign store_full = push_req && !merge && (count_q == FULL_CNT);
  assign pop        = (count_q != '0) && bus_ack;
  assign wr_en      = push || merge;
  assign wr_idx     = merge ? tail_idx : wr_ptr_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    count_d  = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  sb_entry_ram #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_ram (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_idx     (wr_idx),
    .wr_entry   (wr_entry),
    .pop_en     (pop),
    .pop_idx    (rd_ptr_q),
    .rd_idx     (rd_ptr_q),
    .rd_entry   (head_entry),
    .tail_idx   (tail_idx),
    .tail_entry (tail_entry),
    .cmp_addr   (ld_addr[31:2]),
    .match_vec  (match_vec)
  );

  // Bus fields are forced to zero while idle so reset and empty states show
  // a clean bus regardless of stale storage contents.
  assign bus_req    = (count_q != '0);
  assign bus_addr   = bus_req ? {head_entry.addr, 2'b00} : '0;
  assign bus_wdata  = bus_req ? head_entry.data : '0;
  assign bus_byteen = bus_req ? head_entry.byteen : '0;
  assign empty      = !bus_req;
  assign ld_hazard  = ld_valid && (match_vec != '0);

endmodule

// File: tb/tb_m_store_buffer.sv
// tb_m_store_buffer: directed self-checking bench for m_store_buffer.
module tb_m_store_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic [3:0]  in_byteen;
  logic        store_full;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_hazard;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_byteen;
  logic        bus_ack;
  logic        empty;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  m_store_buffer dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_addr    (in_addr),
    .in_wdata   (in_wdata),
    .in_byteen  (in_byteen),
    .store_full (store_full),
    .ld_valid   (ld_valid),
    .ld_addr    (ld_addr),
    .ld_hazard  (ld_hazard),
    .bus_req    (bus_req),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_byteen (bus_byteen),
    .bus_ack    (bus_ack),
    .empty      (empty)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled
  // 1-2 time units after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    in_valid  = 1'b1;
    in_addr   = a;
    in_wdata  = d;
    in_byteen = be;
  endtask

  task automatic idle_store();
    in_valid  = 1'b0;
    in_byteen = 4'b0000;
  endtask

  // Check the head, pop it with a one-cycle ack.
  task automatic expect_pop(input string tag, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] be);
    #1;
    check({tag, "_req"}, 32'(bus_req), 32'd1);
    check({tag, "_addr"}, bus_addr, a);
    check({tag, "_data"}, bus_wdata, d);
    check({tag, "_be"}, 32'(bus_byteen), 32'(be));
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle_store();
    in_addr  = '0;
    in_wdata = '0;
    ld_valid = 1'b0;
    ld_addr  = '0;
    bus_ack  = 1'b0;
    #2;
    check("rst_req", 32'(bus_req), 32'd0);
    check("rst_addr", bus_addr, 32'd0);
    check("rst_data", bus_wdata, 32'd0);
    check("rst_be", 32'(bus_byteen), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(store_full), 32'd0);
    check("rst_haz", 32'(ld_hazard), 32'd0);
    step();
    reset = 1'b0;
    step();

    // Single store, held by bus for 3 cycles before ack.
    drive_store(32'h0000_1006, 32'hABCD_ABCD, 4'b1100);
    step();
    idle_store();
    #1;
    for (int i = 0; i < 3; i++) begin
      check("hold_req", 32'(bus_req), 32'd1);
      check("hold_addr", bus_addr, 32'h0000_1004);
      check("hold_data", bus_wdata, 32'hABCD_ABCD);
      check("hold_be", 32'(bus_byteen), 32'(4'b1100));
      step();
    end
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    #1;
    check("single_empty", 32'(empty), 32'd1);
    check("single_req", 32'(bus_req), 32'd0);

    // A zero-byteen store is ignored.
    drive_store(32'h0000_0800, 32'h1234_5678, 4'b0000);
    #1;
    check("be0_full", 32'(store_full), 32'd0);
    step();
    idle_store();
    #1;
    check("be0_empty", 32'(empty), 32'd1);

    // Fill four entries, fifth stalls; no pass-through on the popping cycle.
    for (int i = 1; i <= 4; i++) begin
      drive_store(32'(i * 16), 32'hD000_0000 | 32'(i * 16), 4'hF);
      #1;
      check("fill_full", 32'(store_full), 32'd0);
      step();
    end
    drive_store(32'h50, 32'hD000_0050, 4'hF);
    #1;
    check("full_5th", 32'(store_full), 32'd1);
    bus_ack = 1'b1;
    #1;
    check("full_nopass", 32'(store_full), 32'd1);
    check("full_head", bus_addr, 32'h10);
    step();
    bus_ack = 1'b0;
    #1;
    check("full_release", 32'(store_full), 32'd0);
    step();
    idle_store();
    for (int i = 2; i <= 5; i++) begin
      expect_pop("order", 32'(i * 16), 32'hD000_0000 | 32'(i * 16), 4'hF);
    end
    #1;
    check("order_empty", 32'(empty), 32'd1);

    // Load hazard against a pending store.
    drive_store(32'h2000, 32'h5555_5555, 4'hF);
    step();
    idle_store();
    ld_valid = 1'b1;
    ld_addr  = 32'h2003;
    #1;
    check("haz_hit", 32'(ld_hazard), 32'd1);
    ld_addr = 32'h2004;
    #1;
    check("haz_other", 32'(ld_hazard), 32'd0);
    ld_addr = 32'h2003;
    bus_ack = 1'b1;
    #1;
    check("haz_head", 32'(ld_hazard), 32'd1);
    step();
    bus_ack = 1'b0;
    #1;
    check("haz_clear", 32'(ld_hazard), 32'd0);
    ld_valid = 1'b0;
    #1;
    check("haz_noload", 32'(ld_hazard), 32'd0);

    // Streaming: ack held high, one store per cycle, count stays 1.
    bus_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_store(32'h100 + 32'(i * 4), 32'(i), 4'hF);
      step();
      check("stream_addr", bus_addr, 32'h100 + 32'(i * 4));
      check("stream_full", 32'(store_full), 32'd0);
    end
    idle_store();
    step();
    check("stream_empty", 32'(empty), 32'd1);
    bus_ack = 1'b0;

    // Asynchronous reset mid-cycle with three pending entries.
    for (int i = 0; i < 3; i++) begin
      drive_store(32'h400 + 32'(i * 4), 32'hCAFE_0000, 4'hF);
      step();
    end
    idle_store();
    #2;
    check("arst_pre", 32'(bus_req), 32'd1);
    reset = 1'b1;
    #1;
    check("arst_req", 32'(bus_req), 32'd0);
    check("arst_empty", 32'(empty), 32'd1);
    check("arst_addr", bus_addr, 32'd0);
    step();
    reset   = 1'b0;
    bus_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("arst_quiet", 32'(bus_req), 32'd0);
    end
    bus_ack = 1'b0;

    // Same-word stores behind a different head: merge when enabled.
    drive_store(32'h300, 32'h1111_1111, 4'b0001);
    step();
    drive_store(32'h500, 32'h2222_2222, 4'b0001);
    step();
    drive_store(32'h501, 32'h3333_3333, 4'b0010);
    step();
    idle_store();
    expect_pop("mrg_a", 32'h300, 32'h1111_1111, 4'b0001);
`ifdef STORE_MERGE_EN
    expect_pop("mrg_b", 32'h500, 32'h2222_3322, 4'b0011);
`else
    expect_pop("mrg_b", 32'h500, 32'h2222_2222, 4'b0001);
    expect_pop("mrg_c", 32'h500, 32'h3333_3333, 4'b0010);
`endif
    #1;
    check("mrg_empty", 32'(empty), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/m_store_buffer.md
Name: m_store_buffer

Overview:
- Posted-write FIFO in the memory stage, directly downstream of the store byte-enable unit.
- Captures its outputs (word address, replicated write data, 4-bit byte enable) and drains them to the data-memory/bridge bus with a req/ack handshake.
- Decouples pipeline stores from bus latency. Flags a stall when it is full, or when a load targets a word that still has a pending store.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2
- PTR_W, 2, log2(DEPTH); pointer width

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  store presented this cycle (M-stage DMWr qualified by no stall)
- in_addr  input  32  store byte address; only [31:2] is stored
- in_wdata  input  32  lane-replicated write data
- in_byteen  input  4  byte enables; 4'b0000 means no store
- store_full  output  1  stall request: a store is presented but cannot be accepted
- ld_valid  input  1  load in M stage this cycle
- ld_addr  input  32  load byte address
- ld_hazard  output  1  stall request: load word matches a pending entry
- bus_req  output  1  head entry valid on bus
- bus_addr  output  32  head word address, low two bits 2'b00
- bus_wdata  output  32  head data
- bus_byteen  output  4  head byte enables
- bus_ack  input  1  bus accepts the head this cycle
- empty  output  1  no pending entries (used as a barrier, e.g. before eret or mfc0)

Behaviour:
- Reset (asynchronous, active-high, takes effect immediately):
  - count, rd_ptr and wr_ptr clear to 0; all entry valid bits clear.
  - bus_req=0, bus_addr=0, bus_wdata=0, bus_byteen=0, empty=1, store_full=0, ld_hazard=0.
  - Reset mid-transaction discards every pending entry; bus_req drops in the same cycle.
- Enqueue: accepted at the clock edge when in_valid=1, in_byteen!=0 and count<DEPTH.
  - The entry {in_addr[31:2], in_wdata, in_byteen} is written at wr_ptr; wr_ptr increments mod DEPTH.
  - in_valid with in_byteen=0 is ignored and never stalls.
- store_full is combinational: in_valid and in_byteen!=0 and count==DEPTH.
  - No pass-through: a pop in the same cycle does not free a slot for that cycle's store.
  - The store is accepted the following cycle.
- Bus outputs:
  - bus_req = (count!=0). bus_addr, bus_wdata and bus_byteen are driven from the head entry, muxed from storage.
  - bus_addr = {head_addr, 2'b00}.
  - While bus_req=1 and bus_ack=0, all bus outputs hold stable.
- Dequeue: at an edge with bus_req=1 and bus_ack=1, the head pops and rd_ptr increments mod DEPTH. bus_ack with bus_req=0 is ignored.
- Latency: a store accepted at edge N drives bus_req from cycle N+1 when the buffer was empty.
  - Minimum residency is 1 cycle; sustained throughput is 1 store per cycle with bus_ack held high.
- Simultaneous push and pop: count is unchanged; both pointers advance.
- Count arithmetic:
  - count has PTR_W+1 bits.
  - count_next = count + push - pop, where push and pop are accepted events.
  - Never overflows or underflows by construction.
- ld_hazard (combinational):
  - ld_valid=1 and any valid entry has addr[31:2]==ld_addr[31:2]; the entry may be the head currently on the bus.
  - Full-word compare only, with no byte-overlap refinement and no forwarding.
  - Clears in the cycle after the last matching entry pops.
- empty = (count==0).
- Ordering: strict FIFO. Stores reach the bus in program order, and no entry is reordered.

Optional Feature:
- Macro STORE_MERGE_EN.
- Defined: an incoming store merges into the tail entry when all of the following hold:
  - in_valid=1 and in_byteen!=0
  - count>=2, so the tail is not the head being presented on the bus
  - in_addr[31:2] equals the tail word address
- On a merge:
  - Each byte lane k with in_byteen[k]=1 overwrites tail data[8k+7:8k]; the tail byteen becomes old|new.
  - count and wr_ptr are unchanged.
  - A merge is accepted even when count==DEPTH, so store_full stays 0 for mergeable stores.
- Not defined: every store allocates a new entry. Identical behaviour to the above with no merge logic synthesised.

Decomposition:
- Shared constants header (constants.v): SB_DEPTH default and the byteen width (4).
- One natural sub-module, sb_entry_ram: DEPTH x 66-bit register file with write port, head read port and an associative word-compare vector for ld_hazard.
- Pointers, count and the merge mux stay in the top module.

Test Plan:
- Reset, then one store in_addr=0x0000_1006, in_wdata=0xABCD_ABCD, in_byteen=4'b1100 with bus_ack=0 -> next cycle bus_req=1, bus_addr=0x0000_1004, bus_byteen=4'b1100; outputs hold for 3 cycles until bus_ack=1; then empty=1.
- Four stores to 0x10, 0x20, 0x30, 0x40 with bus_ack=0, then a fifth to 0x50 -> store_full=1 on the fifth. Pulse bus_ack once -> 0x10 drains, 0x50 is accepted next cycle, and order on the bus is 0x20, 0x30, 0x40, 0x50.
- Buffer holds a store to 0x2000 and a load of ld_addr=0x2003 is presented -> ld_hazard=1; after the entry pops -> ld_hazard=0. A load at 0x2004 gives ld_hazard=0 throughout.
- bus_ack held 1 with a store every cycle -> count stays 1 and one bus transfer occurs per cycle.
- Reset asserted asynchronously mid-cycle with 3 entries pending -> bus_req=0 immediately, empty=1, and no further bus transfers occur.
- STORE_MERGE_EN with bus_ack=0: sb 0x11 at 0x300, then sb 0x22 at 0x500, then sb 0x33 at 0x501 -> the last two merge into one entry with byteen=4'b0011 and data[15:0]=0x3322; count=2.
